// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 multiply path: FSM encoding, default width,
// and the hi/lo register indices written by the multiply sequencer.
package mips16_pkg;

  // Multiply sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam int unsigned MULT_WIDTH = 16;
  localparam int unsigned HI_REG_IDX = 14;
  localparam int unsigned LO_REG_IDX = 13;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add multiply datapath: holds the multiplicand, the accumulator
// and the multiplier/low-product register, and exposes the result of the next
// step so the sequencer can capture the final product on the last step.
module mult_shift_add_dp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] next_prod_c
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   sum_c;

  // One step: add multiplicand when P[0] is set, carry kept in bit WIDTH, then shift right.
  assign sum_c       = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign next_prod_c = {sum_c, mplier[WIDTH-1:1]};

  // Operand latch on load, one shift-add step per BUSY cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
    end else if (step) begin
      {acc, mplier} <= next_prod_c;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multiply sequencer beside the ALU: stalls the single-cycle core while a
// WIDTH-step shift-add multiply runs, then pulses ready/hi_lo_sl with hi/lo.
// Optional feature: define MULT_SIGNED_EN for two's-complement operands.
module mult_seq_ctrl
  import mips16_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             instr_stall_sl,
  output logic             ready,
  output logic             hi_lo_sl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  mult_state_e      state;
  logic [CNT_W-1:0] count;
  logic             load_c;
  logic             step_c;
  logic [WIDTH-1:0] mcand_mag_c;
  logic [WIDTH-1:0] mplier_mag_c;
  logic [PW-1:0]    next_prod_c;
  logic [PW-1:0]    result_c;

  assign load_c = (state == IDLE) && start;
  assign step_c = (state == BUSY);

  // Combinational so the mult is held in its own decode cycle; released in DONE.
  assign instr_stall_sl = load_c || step_c;

`ifdef MULT_SIGNED_EN
  logic sign;

  // Magnitudes feed the unsigned datapath; -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1).
  assign mcand_mag_c  = multiplicand[WIDTH-1] ? WIDTH'(-multiplicand) : multiplicand;
  assign mplier_mag_c = multiplier[WIDTH-1]   ? WIDTH'(-multiplier)   : multiplier;
  assign result_c     = sign ? PW'(-next_prod_c) : next_prod_c;

  // Result sign captured with the operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign <= 1'b0;
    end else if (load_c) begin
      sign <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end
  end
`else
  assign mcand_mag_c  = multiplicand;
  assign mplier_mag_c = multiplier;
  assign result_c     = next_prod_c;
`endif

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clock      (clock),
    .reset      (reset),
    .load       (load_c),
    .step       (step_c),
    .mcand_in   (mcand_mag_c),
    .mplier_in  (mplier_mag_c),
    .next_prod_c(next_prod_c)
  );

  // Sequencer FSM, step counter and registered ready/write-enable/hi/lo.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      ready    <= 1'b0;
      hi_lo_sl <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      ready    <= 1'b0;
      hi_lo_sl <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            count <= '0;
          end
        end
        BUSY: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            ready     <= 1'b1;
            hi_lo_sl  <= 1'b1;
            {hi, lo}  <= result_c;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: expected products are pushed to a queue when
// an operation is started and popped when ready pulses.
module tb_mult_seq_ctrl;

  localparam int unsigned W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         instr_stall_sl;
  logic         ready;
  logic         hi_lo_sl;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int          pass_cnt  = 0;
  int          fail_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  mult_seq_ctrl #(
    .WIDTH(W),
    .CNT_W(5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .instr_stall_sl(instr_stall_sl),
    .ready         (ready),
    .hi_lo_sl      (hi_lo_sl),
    .hi            (hi),
    .lo            (lo)
  );

  function automatic logic [31:0] model_mult(input logic [15:0] a, input logic [15:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return 32'(sa * sb);
`else
    return {16'h0000, a} * {16'h0000, b};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() != 0) return exp_q.pop_front();
    return 32'hxxxxxxxx;
  endfunction

  // Starts one multiply from IDLE (caller sits just after a rising edge) and tracks it to ready.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    int          stall_cyc;
    bit          got;
    logic [31:0] exp;
    exp = 32'h0;
    got = 1'b0;
    exp_q.push_back(model_mult(a, b));
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    #1;
    check({tag, " stall_in_start_cycle"}, 32'(instr_stall_sl), 32'd1);
    stall_cyc = 1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) begin
        start        = 1'b0;
        multiplicand = ~a;
        multiplier   = b ^ 16'h5a5a;
      end
      if (ready) begin
        got = 1'b1;
        exp = pop_exp();
        check({tag, " latency"},   32'(c), 32'd17);
        check({tag, " stall_done"}, 32'(instr_stall_sl), 32'd0);
        check({tag, " hi_lo_sl"},  32'(hi_lo_sl), 32'd1);
        check({tag, " product"},   {hi, lo}, exp);
        break;
      end else if (instr_stall_sl) begin
        stall_cyc++;
      end
    end
    if (!got) check({tag, " ready_timeout"}, 32'd0, 32'd1);
    check({tag, " stall_cycles"}, 32'(stall_cyc), 32'd17);
    @(posedge clock);
    #1;
    check({tag, " ready_pulse_end"}, 32'({ready, hi_lo_sl}), 32'd0);
    check({tag, " hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int extra;
    int pulses;

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hilo",  {hi, lo}, 32'd0);
    check("reset_flags", 32'({ready, hi_lo_sl, instr_stall_sl}), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_op(16'd3, 16'd5, "mul_3x5");
    check("mul_3x5_const", {hi, lo}, 32'h0000_000F);
    run_op(16'hFFFF, 16'hFFFF, "mul_ffff");
`ifdef MULT_SIGNED_EN
    check("mul_ffff_const", {hi, lo}, 32'h0000_0001);
`else
    check("mul_ffff_const", {hi, lo}, 32'hFFFE_0001);
`endif
    run_op(16'h0000, 16'h1234, "mul_zero");
    check("mul_zero_const", {hi, lo}, 32'd0);
    run_op(16'h8001, 16'h7FFF, "mul_mix");
    for (int i = 0; i < 3; i++) begin
      run_op(16'($urandom), 16'($urandom), "mul_rand");
    end
`ifdef MULT_SIGNED_EN
    run_op(16'hFFFD, 16'd5, "smul_m3x5");
    check("smul_m3x5_const", {hi, lo}, 32'hFFFF_FFF1);
    run_op(16'h8000, 16'h8000, "smul_min");
    check("smul_min_const", {hi, lo}, 32'h4000_0000);
`endif

    // start held high with operands changing every cycle: only latch-edge operands count.
    extra = 0;
    for (int c = 0; c < 36; c++) begin
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
      start        = 1'b1;
      if (c == 0 || c == 18) exp_q.push_back(model_mult(multiplicand, multiplier));
      @(posedge clock);
      #1;
      if (c == 16 || c == 34) begin
        check("held_ready", 32'(ready), 32'd1);
        check("held_stall_done", 32'(instr_stall_sl), 32'd0);
        check("held_product", {hi, lo}, pop_exp());
      end else if (ready) begin
        extra++;
      end
      if (c == 17) check("held_stall_restart", 32'(instr_stall_sl), 32'd1);
    end
    start = 1'b0;
    check("held_extra_ready", 32'(extra), 32'd0);

    // Reset in the middle of BUSY discards the product.
    multiplicand = 16'h1234;
    multiplier   = 16'h00FF;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_hilo",  {hi, lo}, 32'd0);
    check("midreset_flags", 32'({ready, hi_lo_sl, instr_stall_sl}), 32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (ready || hi_lo_sl) pulses++;
    end
    check("midreset_no_ready", 32'(pulses), 32'd0);
    run_op(16'h1234, 16'h00FF, "after_reset");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
